// File: rtl/time_sender_pkg.sv
// Shared types and constants for the BCD time to ASCII frame sender.
// Frame layout: "HH:MM:SS.CC" optionally followed by CR LF.
package time_sender_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam int FRAME_LEN_CRLF   = 13;
  localparam int FRAME_LEN_NOCRLF = 11;

  // Index of the final byte of a frame for the chosen line ending.
  function automatic logic [3:0] last_index(input bit send_crlf);
    return send_crlf ? 4'(FRAME_LEN_CRLF - 1) : 4'(FRAME_LEN_NOCRLF - 1);
  endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal codes map to '?'.
module bcd_to_ascii
  import time_sender_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    if (digit <= 4'd9) begin
      ascii = ASCII_ZERO + {4'h0, digit};
    end else begin
      ascii = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/time_ascii_sender.sv
// Serialises a snapshot of the 8-digit BCD time into "HH:MM:SS.CC[\r\n]"
// over a valid/ready byte interface; one request may be queued while busy.
module time_ascii_sender
  import time_sender_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_req,
  input  logic [31:0] bcd_in,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST = last_index(SEND_CRLF);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [31:0] snap, snap_nxt;
  logic        pending, pending_nxt;
  logic        done_nxt;
  logic        hs;
  logic [7:0]  digit_ascii [8];
  logic [7:0]  byte_nxt;

  // tx_valid is a registered copy of (state == SEND), so this is the transfer.
  assign hs = (state == SEND) && tx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    snap_nxt    = snap;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (send_req || pending) begin
          state_nxt   = SEND;
          idx_nxt     = 4'd0;
          snap_nxt    = bcd_in;
          pending_nxt = 1'b0;
        end
      end
      SEND: begin
        if (send_req) begin
          pending_nxt = 1'b1;
        end
        if (hs) begin
          if (idx == LAST) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Converters look at the next snapshot so tx_data can be registered
  // in the same cycle the frame starts.
  for (genvar g = 0; g < 8; g++) begin : g_digit
    bcd_to_ascii u_conv (
      .digit (snap_nxt[4*g +: 4]),
      .ascii (digit_ascii[g])
    );
  end

  always_comb begin
    byte_nxt = 8'h00;
    case (idx_nxt)
      4'd0:    byte_nxt = digit_ascii[7];
      4'd1:    byte_nxt = digit_ascii[6];
      4'd2:    byte_nxt = ASCII_COLON;
      4'd3:    byte_nxt = digit_ascii[5];
      4'd4:    byte_nxt = digit_ascii[4];
      4'd5:    byte_nxt = ASCII_COLON;
      4'd6:    byte_nxt = digit_ascii[3];
      4'd7:    byte_nxt = digit_ascii[2];
      4'd8:    byte_nxt = ASCII_DOT;
      4'd9:    byte_nxt = digit_ascii[1];
      4'd10:   byte_nxt = digit_ascii[0];
      4'd11:   byte_nxt = ASCII_CR;
      4'd12:   byte_nxt = ASCII_LF;
      default: byte_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= 4'd0;
      snap     <= 32'h0;
      pending  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      snap     <= snap_nxt;
      pending  <= pending_nxt;
      tx_valid <= (state_nxt == SEND);
      tx_data  <= (state_nxt == SEND) ? byte_nxt : 8'h00;
      busy     <= (state_nxt == SEND);
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/time_ascii_sender.md
# time_ascii_sender

Serialises the 8-digit BCD time word produced by the FND display controller (`fnd_to_sender`) into an ASCII text frame "HH:MM:SS.CC" plus optional CR LF. It pushes the frame one byte at a time into the UART transmitter through a valid/ready byte handshake. It sits directly downstream of the display controller and upstream of the UART TX. A request snapshots the time word, so a frame is always internally consistent.

## Interface
Parameters:
- `SEND_CRLF`, default 1: 1 appends CR (0x0D) and LF (0x0A), for a 13-byte frame; 0 gives an 11-byte frame.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `send_req`  in  1  request to transmit the current time; level sampled every cycle.
- `bcd_in`  in  32  {h10,h1,m10,m1,s10,s1,ms10,ms1}, 4 bits each, MSB first.
- `tx_ready`  in  1  UART TX can accept a byte this cycle.
- `tx_valid`  out  1  `tx_data` holds a byte to transfer.
- `tx_data`  out  8  ASCII byte.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after the final byte of a frame is accepted.

## Operation
- Transfer rule: a byte moves on a rising edge where `tx_valid` and `tx_ready` are both 1.
- States:
  - IDLE: `tx_valid`=0.
  - SEND: `tx_valid`=1, `tx_data` = frame[idx].
- IDLE → SEND when `send_req`=1 or `pending`=1.
  - In that same cycle: `bcd_in` is latched into `snap`, `idx` is set to 0, and `pending` is cleared.
- SEND, handshake with idx < LAST: idx increments.
- SEND, handshake with idx = LAST → IDLE, and `done` is set for the next cycle.
  - LAST = 12 when `SEND_CRLF`=1, 10 when 0.
- SEND, no handshake: hold state, idx and `tx_data`.
- Frame order: h10, h1, ':'(0x3A), m10, m1, ':'(0x3A), s10, s1, '.'(0x2E), ms10, ms1, then CR, LF if enabled.
- Digit encoding:
  - 0–9 → 0x30 + digit.
  - 10–15 → '?' (0x3F).
- `send_req` while `busy`=1 (including the cycle of the final handshake) sets `pending`.
  - Only one request is queued; further requests are absorbed.
- A queued frame snapshots `bcd_in` when it starts, not at request time.
- `send_req` held high in IDLE starts back-to-back frames. This is intended; callers pulse `send_req`.
- `snap` never changes during a frame; `bcd_in` changes mid-frame have no effect.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `done`=0, state IDLE, idx 0, `pending` 0, `snap` 0.
- Reset assertion clears outputs asynchronously, mid-frame included. The partial frame is abandoned and `done` is not issued.
- After reset release, nothing is sent until a new `send_req`.
- Request latency: `send_req` sampled in IDLE at edge N → `tx_valid`=1 with byte 0 from N+1.
- With `tx_ready` held 1: one byte per cycle; `busy` is high for exactly 13 cycles (11 if `SEND_CRLF`=0).
- Final handshake at edge M:
  - `busy`=0 and `done`=1 during cycle M+1.
  - A queued frame starts at M+1 and has `tx_valid` from M+2, giving a one-cycle gap between frames.
- `tx_valid` never drops without a handshake. `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `time_sender_pkg`:
  - State enum {IDLE, SEND}.
  - ASCII constants: ASCII_ZERO 8'h30, ASCII_COLON 8'h3A, ASCII_DOT 8'h2E, ASCII_CR 8'h0D, ASCII_LF 8'h0A, ASCII_QMARK 8'h3F.
  - FRAME_LEN_CRLF = 13, FRAME_LEN_NOCRLF = 11.
- Sub-module `bcd_to_ascii`: combinational, 4-bit digit in, 8-bit ASCII out, with the '?' rule. It is used by the frame-byte multiplexer.
- The top level holds the FSM, index counter, snapshot register, pending flag and output registers.

## Test plan
- Basic frame: `bcd_in`=0x12345678, one-cycle `send_req`, `tx_ready`=1.
  - Bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A on 13 consecutive cycles.
  - `done` one cycle after 0A; `busy` high for 13 cycles.
- Backpressure: same frame with `tx_ready` pseudo-random, 30% high.
  - Identical byte sequence, no byte lost or duplicated.
  - `tx_data` and `tx_valid` stable on every stalled cycle.
- Snapshot: `bcd_in` changes from 0x23595999 to 0x00000000 after byte 2 is accepted.
  - Frame reads "23:59:59.99\r\n".
- Queueing: three `send_req` pulses during a frame, plus one at the final-handshake cycle.
  - Exactly one extra frame, started one cycle after `done`, carrying the `bcd_in` value at its start cycle.
- Encoding/parameter: `bcd_in`=0xA0000000 with `SEND_CRLF`=0.
  - 11 bytes: 3F 30 3A 30 30 3A 30 30 2E 30 30; `done` after byte 11.
- Reset mid-frame: `reset`=0 while byte 5 is presented.
  - `tx_valid`, `busy` and `done` go to 0 immediately.
  - After release, `tx_valid` stays 0 until the next `send_req`, which yields a full frame from byte 0.
